// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  // Operation sequencing: wait for a request, walk the bits, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width the subtractor is normally built at (the ALU's 4-bit datapath).
  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count 0 .. w-1 processed bit positions.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single full-subtractor cell: d = x - y - bi, one bit, with borrow-out.
// Subtract counterpart of the adder's full-adder cell; purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when x is 0 against a 1, or when x equals y and a borrow is pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// The ripple chain is folded into one full_subtractor cell and a borrow flop.
// Optional signed-overflow flag is built only when SERIAL_SUB_OVF_EN is defined;
// otherwise ovf is a constant 0.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, b_sr_q;
  logic [WIDTH-2:0]   res_q, res_d;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               accept;
  logic               last_bit;
  logic               d_bit;
  logic               bo_bit;

  full_subtractor u_fs (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bi (br_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Result shift register: new bit enters at the top, older bits move down.
  // Only WIDTH-1 bits are stored; the final bit goes straight into diff.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res
    if (gi == WIDTH - 2) begin : g_top
      assign res_d[gi] = d_bit;
    end else begin : g_mid
      assign res_d[gi] = res_q[gi+1];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and accept decode; a request is honoured only outside SHIFT.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/borrow/count datapath and result capture on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sr_q <= a;
      b_sr_q <= b;
      br_q   <= bin;
      cnt_q  <= '0;
      res_q  <= '0;
    end else if (state_q == SHIFT) begin
      a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
      br_q   <= bo_bit;
      cnt_q  <= cnt_q + CNT_W'(1);
      res_q  <= res_d;
      if (last_bit) begin
        diff_q <= {d_bit, res_q};
        bout_q <= bo_bit;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Capture operand sign bits at accept; flag overflow when the result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == SHIFT && last_bit) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready = (state_q != SHIFT);
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule
